// File: rtl/enigma_pkg.sv
// enigma_pkg -- shared constants and types for the enigma UART output path.
//
// Contents:
//   LETTER_W     width of a cipher letter code (0..25 = A..Z)
//   ASCII_A      ASCII code of 'A'; letters map to ASCII_A + code
//   ASCII_SPACE  group separator character
//   ASCII_UNK    substitute for codes 26..31 ('?')
//   BAUD_W       width of the baud down-counter (covers CLKS_PER_BIT up to 4095)
//   BIT_W        width of the data-bit counter (8 bits per frame)
//   GROUP_W      width of the letters-per-group counter (GROUP up to 15)
//   tx_state_e   transmit FSM states
package enigma_pkg;

  localparam int LETTER_W = 5;
  localparam int BAUD_W   = 12;
  localparam int BIT_W    = 3;
  localparam int GROUP_W  = 4;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UNK   = 8'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/enigma_fifo.sv
// enigma_fifo -- small synchronous FIFO buffering letters ahead of the UART.
//
// Parameters:
//   WIDTH   data width
//   DEPTH   number of entries (default 4)
// Ports:
//   clk      clock, all state changes on rising edge
//   rst      synchronous active-high reset: pointers and count cleared
//   push_i   write wdata_i this edge (ignored when full)
//   wdata_i  data to write
//   pop_i    discard the head entry this edge (ignored when empty)
//   rdata_o  head entry, valid whenever empty_o is 0
//   full_o   all DEPTH entries occupied
//   empty_o  no entries occupied
//   count_o  number of occupied entries
//
// Handshake: push_i is only honoured when full_o is low, pop_i only when
// empty_o is low; full_o reflects the registered count, so a pop in the same
// cycle never frees room for a push in that cycle.
module enigma_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/enigma_uart_tx.sv
// enigma_uart_tx -- turns enigma cipher letters into an 8N1 UART stream of
// ASCII capitals, inserting a space after every GROUP letters.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..4095), default 87
//   GROUP         letters per group before a space (0 = no spaces, max 15)
// Ports:
//   clk           clock, all state changes on rising edge
//   rst           synchronous active-high reset
//   letter_in     cipher letter, 0..25 = A..Z (26..31 sent as '?')
//   letter_valid  letter_in is valid this cycle
//   letter_ready  a letter can be accepted this cycle
//   tx            registered serial line, idle high
//   busy          a frame is in progress or letters are queued
//   dbg_state_o   current transmit FSM state
//
// Handshake: a letter transfers on every rising edge where letter_valid and
// letter_ready are both 1. letter_ready depends only on rst and the FIFO fill
// level, never on letter_valid; valid held while ready is low has no effect.
module enigma_uart_tx
  import enigma_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int GROUP        = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                letter_valid,
  output logic                letter_ready,
  output logic                tx,
  output logic                busy,
  output tx_state_e           dbg_state_o
);

  localparam logic [BAUD_W-1:0]  BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GROUP_W-1:0] GROUP_N   = GROUP_W'(GROUP);
  localparam logic               GROUP_EN  = (GROUP != 0);
  localparam int                 FIFO_CW   = 3;

  tx_state_e           state_q;
  logic                tx_q;
  logic [7:0]          shift_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BIT_W-1:0]    bit_q;
  logic [GROUP_W-1:0]  group_q;

  logic                fifo_push;
  logic                fifo_pop;
  logic [LETTER_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_CW-1:0]  fifo_count;

  logic                bit_end;
  logic                space_due;
  logic [7:0]          head_ascii;

  function automatic logic [7:0] to_ascii(input logic [LETTER_W-1:0] letter);
    if (letter < LETTER_W'(26)) begin
      return ASCII_A + {3'b000, letter};
    end
    return ASCII_UNK;
  endfunction

  enigma_fifo #(
    .WIDTH (LETTER_W),
    .DEPTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (letter_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign letter_ready = !rst && !fifo_full;
  assign fifo_push    = letter_valid && letter_ready;

  assign bit_end    = (baud_q == '0);
  assign space_due  = GROUP_EN && (group_q == GROUP_N);
  assign head_ascii = to_ascii(fifo_head);

  // The FIFO head is consumed on the same edge the FSM loads it into the
  // shifter: from IDLE, or at the end of STOP when no space takes priority.
  always_comb begin
    fifo_pop = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    fifo_pop = !fifo_empty;
        STOP:    fifo_pop = bit_end && !space_due && !fifo_empty;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  // Shifter holds the bits not yet on the line; tx_q is the bit being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      group_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= head_ascii;
            group_q <= group_q + GROUP_W'(1);
            baud_q  <= BAUD_LOAD;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            baud_q  <= BAUD_LOAD;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_q <= BAUD_LOAD;
            if (bit_q == BIT_W'(7)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            if (space_due) begin
              // Space goes out straight after the last letter of a group,
              // even if nothing else is queued; the FIFO is left untouched.
              shift_q <= ASCII_SPACE;
              group_q <= '0;
              baud_q  <= BAUD_LOAD;
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else if (!fifo_empty) begin
              shift_q <= head_ascii;
              group_q <= group_q + GROUP_W'(1);
              baud_q  <= BAUD_LOAD;
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);
  assign dbg_state_o = state_q;

endmodule
